// File: rtl/btn_capture.sv
// btn_capture: synchronize, debounce and latch elevator car/hall buttons; derive request position flags.
module btn_capture #(
  parameter int SAMPLE_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] raw_floor,
  input  logic [7:0] raw_up,
  input  logic [7:0] raw_down,
  input  logic [2:0] floor,
  input  logic       clr,
  input  logic       clr_up,
  output logic [7:0] floor_btn,
  output logic [7:0] up,
  output logic [7:0] down,
  output logic       req_here,
  output logic       req_above,
  output logic       req_below
);
  localparam logic [16:0] LAST = 17'(SAMPLE_DIV - 1);
  logic [23:0] s1_q, s2_q, h0_q, h0_d, h1_q, h1_d, deb_q, deb_d, deb_p_q, rise;
  logic [16:0] cnt_q, cnt_d;
  logic [7:0]  floor_btn_q, floor_btn_d, up_q, up_d, down_q, down_d, sel, any_req;
  logic        tick;
  always_comb begin
    tick        = cnt_q == LAST;
    cnt_d       = tick ? '0 : cnt_q + 17'd1;
    h0_d        = tick ? s2_q : h0_q;
    h1_d        = tick ? h0_q : h1_q;
    // post-shift history is {h1, h0, s2}; level moves only on all-ones or all-zeros
    deb_d       = tick ? ((h1_q & h0_q & s2_q) | (deb_q & (h1_q | h0_q | s2_q))) : deb_q;
    rise        = deb_q & ~deb_p_q;
    sel         = 8'd1 << floor;
    floor_btn_d = (floor_btn_q | rise[7:0]) & ~(clr ? sel : 8'h00);
    up_d        = (up_q | rise[15:8]) & ~(clr && clr_up ? sel : 8'h00) & 8'h7F;
    down_d      = (down_q | rise[23:16]) & ~(clr && !clr_up ? sel : 8'h00) & 8'hFE;
  end
  always_ff @(posedge clk)
    if (rst) begin
      s1_q        <= '0;
      s2_q        <= '0;
      h0_q        <= '0;
      h1_q        <= '0;
      deb_q       <= '0;
      deb_p_q     <= '0;
      cnt_q       <= '0;
      floor_btn_q <= '0;
      up_q        <= '0;
      down_q      <= '0;
    end else begin
      s1_q        <= {raw_down, raw_up, raw_floor};
      s2_q        <= s1_q;
      h0_q        <= h0_d;
      h1_q        <= h1_d;
      deb_q       <= deb_d;
      deb_p_q     <= deb_q;
      cnt_q       <= cnt_d;
      floor_btn_q <= floor_btn_d;
      up_q        <= up_d;
      down_q      <= down_d;
    end
  assign floor_btn = floor_btn_q;
  assign up        = up_q;
  assign down      = down_q;
  assign any_req   = floor_btn_q | up_q | down_q;
  assign req_here  = any_req[floor];
  assign req_above = |(any_req & (8'hFE << floor));
  assign req_below = |(any_req & ~(8'hFF << floor));
endmodule

// File: tb/tb_btn_capture.sv
// tb_btn_capture: directed checks of btn_capture with SAMPLE_DIV=4.
module tb_btn_capture;
  logic       clk = 1'b0;
  logic       rst, clr, clr_up;
  logic [7:0] raw_floor, raw_up, raw_down, floor_btn, up, down;
  logic [2:0] floor;
  logic       req_here, req_above, req_below;
  int         checks = 0;
  int         errors = 0;
  always #5 clk = ~clk;
  btn_capture #(.SAMPLE_DIV(4)) dut (
    .clk(clk), .rst(rst), .raw_floor(raw_floor), .raw_up(raw_up), .raw_down(raw_down),
    .floor(floor), .clr(clr), .clr_up(clr_up), .floor_btn(floor_btn), .up(up), .down(down),
    .req_here(req_here), .req_above(req_above), .req_below(req_below)
  );
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask
  task automatic chk_req(input string tag, input logic h, input logic a, input logic b);
    chk(tag, {5'b0, req_here, req_above, req_below}, {5'b0, h, a, b});
  endtask
  initial begin
    rst = 1'b1; clr = 1'b0; clr_up = 1'b0; floor = 3'd0;
    raw_floor = '0; raw_up = '0; raw_down = '0;
    step(3);
    chk("rst_floor_btn", floor_btn, 8'h00);
    chk("rst_up", up, 8'h00);
    chk("rst_down", down, 8'h00);
    chk_req("rst_req", 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    // car button 3 from floor 0
    step(2);
    raw_floor = 8'h08;
    step(5);
    chk("press_early", floor_btn, 8'h00);
    for (int i = 0; i < 11 && floor_btn !== 8'h08; i++) step(1);
    chk("press_latch", floor_btn, 8'h08);
    chk_req("press_req_f0", 1'b0, 1'b1, 1'b0);
    floor = 3'd3;
    step(1);
    chk_req("press_req_f3", 1'b1, 1'b0, 1'b0);
    floor = 3'd7;
    step(1);
    chk_req("press_req_f7", 1'b0, 1'b0, 1'b1);
    raw_floor = '0;
    // short glitch must not latch
    do_reset();
    raw_up = 8'h04;
    step(5);
    raw_up = '0;
    step(30);
    chk("glitch_up", up, 8'h00);
    // nonexistent buttons stay clear
    do_reset();
    raw_up = 8'hC0; raw_down = 8'h01;
    for (int i = 0; i < 40; i++) begin
      step(1);
      chk("up7_zero", {7'b0, up[7]}, 8'h00);
      chk("down0_zero", {7'b0, down[0]}, 8'h00);
    end
    chk("up6_latched", up, 8'h40);
    chk("down_none", down, 8'h00);
    raw_up = '0; raw_down = '0;
    // directional clear at floor 2
    do_reset();
    floor = 3'd2;
    raw_up = 8'h04; raw_down = 8'h04; raw_floor = 8'h04;
    step(20);
    raw_up = '0; raw_down = '0; raw_floor = '0;
    chk("f2_up", up, 8'h04);
    chk("f2_down", down, 8'h04);
    chk("f2_floor", floor_btn, 8'h04);
    chk_req("f2_req", 1'b1, 1'b0, 1'b0);
    clr = 1'b1; clr_up = 1'b1;
    step(1);
    clr = 1'b0;
    chk("clrup_up", up, 8'h00);
    chk("clrup_down", down, 8'h04);
    chk("clrup_floor", floor_btn, 8'h00);
    clr = 1'b1; clr_up = 1'b0;
    step(1);
    clr = 1'b0;
    chk("clrdn_down", down, 8'h00);
    chk_req("clrdn_req", 1'b0, 1'b0, 1'b0);
    // clear overrides a simultaneous set
    do_reset();
    floor = 3'd5; clr = 1'b1; clr_up = 1'b0;
    raw_floor = 8'h20;
    for (int i = 0; i < 20; i++) begin
      step(1);
      chk("clr_wins", floor_btn, 8'h00);
    end
    clr = 1'b0;
    step(5);
    chk("clr_wins_after", floor_btn, 8'h00);
    raw_floor = '0;
    // full latch, partial clear, reset while held
    do_reset();
    raw_floor = 8'hFF;
    step(20);
    raw_floor = 8'h02;
    chk("all_latched", floor_btn, 8'hFF);
    floor = 3'd7;
    step(1);
    chk_req("all_f7", 1'b1, 1'b0, 1'b1);
    floor = 3'd0;
    step(1);
    chk_req("all_f0", 1'b1, 1'b1, 1'b0);
    floor = 3'd4; clr = 1'b1; clr_up = 1'b0;
    step(1);
    clr = 1'b0;
    chk("clr_f4_only", floor_btn, 8'hEF);
    floor = 3'd1;
    rst = 1'b1;
    step(1);
    chk("rst_mid_floor", floor_btn, 8'h00);
    chk("rst_mid_up", up, 8'h00);
    chk("rst_mid_down", down, 8'h00);
    chk_req("rst_mid_req", 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    step(5);
    chk("repress_early", floor_btn, 8'h00);
    step(15);
    chk("repress_latch", floor_btn, 8'h02);
    chk_req("repress_req", 1'b1, 1'b0, 1'b0);
    raw_floor = '0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
